clock_set_ctrl: RTL and testbench

//  Time-keeping and time-set controller for the 4-digit HH:MM display.

---
 rtl/clock_set_ctrl.sv | 173 +++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-keeping and time-set controller for a 4-digit HH:MM
// display. Keeps BCD hh:mm:ss and runs a RUN / SET_HR / SET_MIN mode machine
// driven by two push keys. While a pair of digits is being edited, that pair
// blinks. Every register sits in the 500 Hz display clock domain.
//
// Ports
//   clk_500hz  in   display/system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   key_mode   in   mode key, debounced level, asynchronous to the clock
//   key_inc    in   increment key, debounced level, asynchronous to the clock
//   time0..3   out  hours tens/units, minutes tens/units (BCD or BLANK_CODE)
//   sec_tick   out  one-cycle pulse on every seconds increment
//   set_mode   out  0=RUN, 1=SET_HR, 2=SET_MIN (registered state)
module clock_set_ctrl #(
    parameter int         TICKS_PER_SEC = 500,
    parameter int         BLINK_HALF    = 125,
    parameter logic [3:0] BLANK_CODE    = 4'hF
) (
    input  logic       clk_500hz,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] time0,
    output logic [3:0] time1,
    output logic [3:0] time2,
    output logic [3:0] time3,
    output logic       sec_tick,
    output logic [1:0] set_mode
);
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = $clog2(2 * BLINK_HALF);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [2:0]    r_mode_sync, r_inc_sync;   // [0],[1] synchroniser, [2] edge register
    logic [TW-1:0] r_tick;
    logic [BW-1:0] r_blink;
    logic [7:0]    r_hh, r_mm, r_ss;          // packed BCD {tens, units}
    logic [3:0]    r_time0, r_time1, r_time2, r_time3;
    logic          r_sec_tick;

    logic       w_mode_edge, w_inc_edge, w_blank;
    logic [8:0] w_ss_inc, w_mm_inc;           // {carry, tens, units}
    logic [7:0] w_hh_inc;

    // BCD +1 modulo 60; bit 8 flags the 59 -> 00 rollover.
    function automatic logic [8:0] inc60(input logic [7:0] v);
        if (v[3:0] != 4'd9)      inc60 = {1'b0, v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd5) inc60 = {1'b0, v[7:4] + 4'd1, 4'd0};
        else                     inc60 = 9'd0 | 9'h100;
    endfunction

    // BCD +1 modulo 24.
    function automatic logic [7:0] inc24(input logic [7:0] v);
        if (v == 8'h23)          inc24 = 8'h00;
        else if (v[3:0] == 4'd9) inc24 = {v[7:4] + 4'd1, 4'd0};
        else                     inc24 = {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_ss_inc = inc60(r_ss);
    assign w_mm_inc = inc60(r_mm);
    assign w_hh_inc = inc24(r_hh);

    // Edge seen after the 2nd sync stage; acts on the 3rd clock edge after the key rises.
    assign w_mode_edge = r_mode_sync[1] & ~r_mode_sync[2];
    assign w_inc_edge  = r_inc_sync[1]  & ~r_inc_sync[2];
    assign w_blank     = (r_blink >= BW'(BLINK_HALF));

    always_ff @(posedge clk_500hz or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_sync <= '0;
            r_inc_sync  <= '0;
        end else begin
            r_mode_sync <= {r_mode_sync[1:0], key_mode};
            r_inc_sync  <= {r_inc_sync[1:0],  key_inc};
        end
    end

    always_ff @(posedge clk_500hz or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:     if (w_mode_edge) w_state_nxt = ST_SET_HR;
            ST_SET_HR:  if (w_mode_edge) w_state_nxt = ST_SET_MIN;
            ST_SET_MIN: if (w_mode_edge) w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_RUN;
        endcase
    end

    // Time keeping, key actions and the blink phase.
    always_ff @(posedge clk_500hz or negedge rst_n) begin
        if (!rst_n) begin
            r_tick     <= '0;
            r_blink    <= '0;
            r_hh       <= '0;
            r_mm       <= '0;
            r_ss       <= '0;
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_mode_edge) begin
                        // Entering SET_HR: freeze with seconds zeroed.
                        r_tick <= '0;
                        r_ss   <= '0;
                    end else if (r_tick == TW'(TICKS_PER_SEC - 1)) begin
                        r_tick     <= '0;
                        r_sec_tick <= 1'b1;
                        r_ss       <= w_ss_inc[7:0];
                        if (w_ss_inc[8]) begin
                            r_mm <= w_mm_inc[7:0];
                            if (w_mm_inc[8]) r_hh <= w_hh_inc;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                ST_SET_HR: begin
                    r_tick <= '0;
                    if (w_inc_edge && !w_mode_edge) r_hh <= w_hh_inc;
                end
                ST_SET_MIN: begin
                    r_tick <= '0;
                    // Minute wrap here deliberately carries nothing into hours.
                    if (w_inc_edge && !w_mode_edge) r_mm <= w_mm_inc[7:0];
                end
                default: r_tick <= '0;
            endcase

            // Restart the visible phase on any press so the edit is seen at once.
            if (w_mode_edge || w_inc_edge || r_state == ST_RUN || r_state == ST_BAD)
                r_blink <= '0;
            else if (r_blink == BW'(2 * BLINK_HALF - 1))
                r_blink <= '0;
            else
                r_blink <= r_blink + BW'(1);
        end
    end

    // Registered digit outputs: follow the internal time one cycle later.
    always_ff @(posedge clk_500hz or negedge rst_n) begin
        if (!rst_n) begin
            r_time0 <= '0;
            r_time1 <= '0;
            r_time2 <= '0;
            r_time3 <= '0;
        end else begin
            r_time0 <= (r_state == ST_SET_HR  && w_blank) ? BLANK_CODE : r_hh[7:4];
            r_time1 <= (r_state == ST_SET_HR  && w_blank) ? BLANK_CODE : r_hh[3:0];
            r_time2 <= (r_state == ST_SET_MIN && w_blank) ? BLANK_CODE : r_mm[7:4];
            r_time3 <= (r_state == ST_SET_MIN && w_blank) ? BLANK_CODE : r_mm[3:0];
        end
    end

    assign time0    = r_time0;
    assign time1    = r_time1;
    assign time2    = r_time2;
    assign time3    = r_time3;
    assign sec_tick = r_sec_tick;
    assign set_mode = r_state;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl (TICKS_PER_SEC=4, BLINK_HALF=2).
// A cycle-level reference model keeps the time as plain integers and applies
// the key/mode/count/blink rules; every cycle all outputs are compared.
module tb_clock_set_ctrl;
    localparam int TPS = 4;
    localparam int BH  = 2;

    logic       clk_500hz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       key_mode  = 1'b0;
    logic       key_inc   = 1'b0;
    logic [3:0] time0, time1, time2, time3;
    logic       sec_tick;
    logic [1:0] set_mode;

    clock_set_ctrl #(.TICKS_PER_SEC(TPS), .BLINK_HALF(BH), .BLANK_CODE(4'hF)) dut (
        .clk_500hz (clk_500hz),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .time0     (time0),
        .time1     (time1),
        .time2     (time2),
        .time3     (time3),
        .sec_tick  (sec_tick),
        .set_mode  (set_mode)
    );

    always #5 clk_500hz = ~clk_500hz;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: seconds of day as integers, mode 0/1/2.
    int m_hh, m_mm, m_ss, m_tick, m_mode, m_blink;
    int e_t[4];
    int e_tick, e_mode;
    // Key levels seen at the last three clock edges (index 0 = most recent).
    bit km[3];
    bit ki[3];

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hh = 0; m_mm = 0; m_ss = 0; m_tick = 0; m_mode = 0; m_blink = 0;
        for (int k = 0; k < 4; k++) e_t[k] = 0;
        e_tick = 0; e_mode = 0;
        for (int k = 0; k < 3; k++) begin km[k] = 0; ki[k] = 0; end
    endtask

    // One clock edge of the reference model, given key levels at that edge.
    task automatic model_step(input bit kmode, input bit kinc);
        bit mev, iev;
        int cur;
        // A key that rose between edges acts on the third edge after the rise.
        mev = km[1] && !km[2];
        iev = ki[1] && !ki[2];
        km[2] = km[1]; km[1] = km[0]; km[0] = kmode;
        ki[2] = ki[1]; ki[1] = ki[0]; ki[0] = kinc;

        // Display reflects the pre-edge time (one cycle of output latency).
        e_t[0] = (m_mode == 1 && m_blink >= BH) ? 15 : m_hh / 10;
        e_t[1] = (m_mode == 1 && m_blink >= BH) ? 15 : m_hh % 10;
        e_t[2] = (m_mode == 2 && m_blink >= BH) ? 15 : m_mm / 10;
        e_t[3] = (m_mode == 2 && m_blink >= BH) ? 15 : m_mm % 10;

        cur = m_mode;
        e_tick = 0;
        if (cur == 0) begin
            if (mev) begin
                m_mode = 1; m_tick = 0; m_ss = 0;
            end else if (m_tick == TPS - 1) begin
                int sod;
                m_tick = 0;
                e_tick = 1;
                sod = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
                m_hh = sod / 3600; m_mm = (sod / 60) % 60; m_ss = sod % 60;
            end else begin
                m_tick++;
            end
        end else if (cur == 1) begin
            if (mev) m_mode = 2;
            else if (iev) m_hh = (m_hh + 1) % 24;
        end else begin
            if (mev) m_mode = 0;
            else if (iev) m_mm = (m_mm + 1) % 60;
        end
        m_blink = (mev || iev || cur == 0) ? 0 : (m_blink + 1) % (2 * BH);
        e_mode = m_mode;
    endtask

    task automatic check_outs();
        chk("time0", time0, e_t[0]);
        chk("time1", time1, e_t[1]);
        chk("time2", time2, e_t[2]);
        chk("time3", time3, e_t[3]);
        chk("sec_tick", sec_tick, e_tick);
        chk("set_mode", set_mode, e_mode);
    endtask

    task automatic cyc();
        @(posedge clk_500hz);
        model_step(key_mode, key_inc);
        #1;
        check_outs();
    endtask

    task automatic press(input bit m, input bit i, input int hold, input int gap);
        key_mode = m;
        key_inc  = i;
        repeat (hold) cyc();
        key_mode = 1'b0;
        key_inc  = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_t0"}, time0, 0);
        chk({tag, "_t1"}, time1, 0);
        chk({tag, "_t2"}, time2, 0);
        chk({tag, "_t3"}, time3, 0);
        chk({tag, "_tick"}, sec_tick, 0);
        chk({tag, "_mode"}, set_mode, 0);
    endtask

    initial begin
        int ticks;
        int guard;
        model_reset();
        repeat (3) @(posedge clk_500hz);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // 1: four cycles from reset, tick on the fourth.
        ticks = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            ticks += sec_tick;
        end
        chk("first_sec_tick", sec_tick, 1);
        chk("tick_count", ticks[7:0], 1);

        // 2: set 23:59, run through 23:59:59 into midnight.
        press(1, 0, 1, 3);
        repeat (23) press(0, 1, 1, 2);
        press(1, 0, 2, 3);
        repeat (59) press(0, 1, 1, 2);
        press(1, 0, 1, 3);
        repeat (60 * TPS + 6) cyc();
        chk("midnight_t1", time1, 0);
        chk("midnight_t3", time3, 0);

        // 3: SET_HR, 25 increments wraps 23->00 on the way to 01.
        press(1, 0, 1, 3);
        repeat (25) press(0, 1, 1, 2);
        repeat (8) cyc();
        chk("sethr_mode", set_mode, 1);

        // 4: SET_MIN, 60 increments back to the start, then RUN.
        press(1, 0, 1, 3);
        repeat (60) press(0, 1, 1, 2);
        repeat (4) cyc();
        press(1, 0, 1, 3);
        repeat (2 * TPS + 2) cyc();

        // 5: both keys in the same cycle from RUN: mode wins.
        press(1, 1, 1, 3);
        chk("both_mode", set_mode, 1);
        repeat (4) cyc();

        // 6: into SET_MIN, wait for a blanked phase, then pulse reset.
        press(1, 0, 1, 3);
        guard = 0;
        while (e_t[2] != 15 && guard < 16) begin
            cyc();
            guard++;
        end
        chk("blank_seen", time2, 15);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk_500hz);
        #1;
        check_zero("rst_hold");
        rst_n = 1'b1;
        model_reset();
        ticks = 0;
        for (int k = 0; k < TPS - 1; k++) begin
            cyc();
            ticks += sec_tick;
        end
        chk("no_early_tick", ticks[7:0], 0);
        cyc();
        chk("tick_after_rel", sec_tick, 1);

        // Randomised key traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) key_mode = ~key_mode;
            if ($urandom_range(0, 3) == 0)  key_inc  = ~key_inc;
            cyc();
        end
        key_mode = 1'b0;
        key_inc  = 1'b0;
        repeat (6) cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
